// File: rtl/pd_relock_seq.sv
// FMDLL false-lock recovery: holds PD/CP in reset, releases in order, declares lock on PD quiet.
// Request path latency 2 clk_ext edges (sync + edge detect); no backpressure, outputs decode state.
module pd_relock_seq #(
   parameter int unsigned INIT_CYC   = 16,
   parameter int unsigned SETTLE_CYC = 4,
   parameter int unsigned LOCK_CYC   = 32,
   parameter int unsigned LOSS_CYC   = 8,
   parameter int unsigned ACQ_TO     = 1024,
   parameter int unsigned CNT_W      = 8
) (
   input  logic             clk_ext,
   input  logic             rst,
   input  logic             reset_pd_req,
   input  logic             up,
   input  logic             dn,
   output logic             pd_rst,
   output logic             cp_init,
   output logic             lock,
   output logic             relock_pulse,
   output logic [CNT_W-1:0] relock_cnt
);

   typedef enum logic [3:0] {
      INIT   = 4'b0001,
      SETTLE = 4'b0010,
      ACQ    = 4'b0100,
      LOCKED = 4'b1000
   } state_t;

   localparam logic [15:0] INIT_LAST   = 16'(INIT_CYC - 1);
   localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);
   localparam logic [15:0] ACQ_LAST    = 16'(ACQ_TO - 1);
   localparam logic [15:0] LOCK_N      = 16'(LOCK_CYC);
   localparam logic [15:0] LOSS_N      = 16'(LOSS_CYC);

   state_t      state, nxt;
   logic        req_s1, req_s2, req_d;
   logic        req_rise;
   logic        quiet;
   logic        restart;
   logic        recov;
   logic [15:0] cnt;
   logic [15:0] streak, streak_nxt, streak_inc;

   assign req_rise   = req_s2 & ~req_d;
   assign quiet      = ~up & ~dn;
   assign streak_inc = streak + 16'd1;

   always_ff @(posedge clk_ext or posedge rst) begin
      if (rst) begin
         req_s1 <= 1'b0;
         req_s2 <= 1'b0;
         req_d  <= 1'b0;
      end else begin
         req_s1 <= reset_pd_req;
         req_s2 <= req_s1;
         req_d  <= req_s2;
      end
   end

   always_ff @(posedge clk_ext or posedge rst) begin
      if (rst) state <= INIT;
      else     state <= nxt;
   end

   // Priority inside each state: request > lock/loss decision > acquisition timeout.
   always_comb begin
      nxt        = state;
      restart    = 1'b0;
      recov      = 1'b0;
      streak_nxt = streak;
      case (state)
         INIT: begin
            if (req_rise)               restart = 1'b1;
            else if (cnt == INIT_LAST)  nxt = SETTLE;
         end
         SETTLE: begin
            if (req_rise) begin
               nxt   = INIT;
               recov = 1'b1;
            end else if (cnt == SETTLE_LAST) begin
               nxt = ACQ;
            end
         end
         ACQ: begin
            streak_nxt = quiet ? streak_inc : 16'd0;
            if (req_rise) begin
               nxt   = INIT;
               recov = 1'b1;
            end else if (quiet && streak_inc == LOCK_N) begin
               nxt = LOCKED;
            end else if (cnt == ACQ_LAST) begin
               nxt   = INIT;
               recov = 1'b1;
            end
         end
         LOCKED: begin
            streak_nxt = quiet ? 16'd0 : streak_inc;
            if (req_rise) begin
               nxt   = INIT;
               recov = 1'b1;
            end else if (!quiet && streak_inc == LOSS_N) begin
               nxt = ACQ;
            end
         end
         default: nxt = INIT;
      endcase
   end

   always_ff @(posedge clk_ext or posedge rst) begin
      if (rst) begin
         cnt          <= 16'd0;
         streak       <= 16'd0;
         relock_pulse <= 1'b0;
         relock_cnt   <= '0;
      end else begin
         cnt          <= (nxt != state || restart) ? 16'd0 : cnt + 16'd1;
         streak       <= (nxt != state) ? 16'd0 : streak_nxt;
         relock_pulse <= recov;
         if (recov && relock_cnt != {CNT_W{1'b1}})
            relock_cnt <= relock_cnt + CNT_W'(1);
      end
   end

   assign cp_init = (state == INIT);
   assign pd_rst  = (state == INIT) || (state == SETTLE);
   assign lock    = (state == LOCKED);

endmodule

// File: tb/tb_pd_relock_seq.sv
// Directed bench for pd_relock_seq: expectations queued per edge number, compared on the falling edge.
module tb_pd_relock_seq;

   logic       clk_ext = 1'b0;
   logic       rst = 1'b1;
   logic       reset_pd_req = 1'b0;
   logic       up = 1'b0;
   logic       dn = 1'b0;
   logic       pd_rst, cp_init, lock, relock_pulse;
   logic [1:0] relock_cnt;

   int total = 0;
   int bad   = 0;
   int edge_n;

   typedef struct {
      int         at;
      logic [5:0] exp;
      string      tag;
   } exp_t;

   exp_t sb[$];

   pd_relock_seq #(.CNT_W(2)) dut (
      .clk_ext      (clk_ext),
      .rst          (rst),
      .reset_pd_req (reset_pd_req),
      .up           (up),
      .dn           (dn),
      .pd_rst       (pd_rst),
      .cp_init      (cp_init),
      .lock         (lock),
      .relock_pulse (relock_pulse),
      .relock_cnt   (relock_cnt)
   );

   always #5 clk_ext = ~clk_ext;

   always @(posedge clk_ext or posedge rst) begin
      if (rst) edge_n <= 0;
      else     edge_n <= edge_n + 1;
   end

   function automatic logic [5:0] v(bit p, bit c, bit l, bit s, int n);
      return {p, c, l, s, 2'(n)};
   endfunction

   task automatic check(string tag, logic [5:0] exp);
      logic [5:0] obs;
      obs = {pd_rst, cp_init, lock, relock_pulse, relock_cnt};
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed {pd_rst,cp_init,lock,pulse,cnt}=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic push(int at, logic [5:0] exp, string tag);
      exp_t e;
      e.at  = at;
      e.exp = exp;
      e.tag = tag;
      sb.push_back(e);
   endtask

   task automatic run_to(int e);
      while (edge_n < e) begin
         @(posedge clk_ext);
         #1;
      end
   endtask

   always @(negedge clk_ext) begin
      while (sb.size() > 0 && sb[0].at <= edge_n) begin
         exp_t e;
         e = sb.pop_front();
         check($sformatf("%s@%0d", e.tag, e.at), e.exp);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time exceeded, edge=%0d", edge_n);
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk_ext);
      #1;
      check("reset_vals", v(1, 1, 0, 0, 0));
      rst = 1'b0;

      // power-up sequence with quiet PD
      push(1,  v(1, 1, 0, 0, 0), "pwr_init");
      push(15, v(1, 1, 0, 0, 0), "pwr_init_last");
      push(16, v(1, 0, 0, 0, 0), "pwr_settle");
      push(19, v(1, 0, 0, 0, 0), "pwr_settle_last");
      push(20, v(0, 0, 0, 0, 0), "pwr_acq");
      push(51, v(0, 0, 0, 0, 0), "pwr_acq_last");
      push(52, v(0, 0, 1, 0, 0), "pwr_lock");
      run_to(60);

      // false-lock request while locked, held 3 cycles, rising before edge 61
      reset_pd_req = 1'b1;
      push(62,  v(0, 0, 1, 0, 0), "req_pending");
      push(63,  v(1, 1, 0, 1, 1), "req_recover");
      push(64,  v(1, 1, 0, 0, 1), "req_pulse_end");
      push(78,  v(1, 1, 0, 0, 1), "rl_init_last");
      push(79,  v(1, 0, 0, 0, 1), "rl_settle");
      push(83,  v(0, 0, 0, 0, 1), "rl_acq");
      push(114, v(0, 0, 0, 0, 1), "rl_acq_last");
      push(115, v(0, 0, 1, 0, 1), "rl_lock");
      run_to(63);
      reset_pd_req = 1'b0;

      // 7 active samples keep lock, 8 drop it without a recovery
      run_to(120);
      dn = 1'b1;
      push(127, v(0, 0, 1, 0, 1), "dn7_held");
      push(128, v(0, 0, 1, 0, 1), "dn7_after");
      run_to(127);
      dn = 1'b0;
      run_to(130);
      dn = 1'b1;
      push(137, v(0, 0, 1, 0, 1), "dn8_pre");
      push(138, v(0, 0, 0, 0, 1), "dn8_loss");
      push(139, v(0, 0, 0, 0, 1), "dn8_acq");
      push(169, v(0, 0, 0, 0, 1), "reacq_pre");
      push(170, v(0, 0, 1, 0, 1), "reacq_lock");
      run_to(138);
      dn = 1'b0;

      // drop to ACQ, then keep streak short with periodic up pulses until timeout
      run_to(180);
      dn = 1'b1;
      push(1000, v(0, 0, 0, 0, 1), "to_mid");
      push(1211, v(0, 0, 0, 0, 1), "to_last");
      push(1212, v(1, 1, 0, 1, 2), "to_recover");
      push(1213, v(1, 1, 0, 0, 2), "to_pulse_end");
      run_to(188);
      dn = 1'b0;
      for (int e = 188; e < 1212; e++) begin
         run_to(e);
         up = (((e + 1 - 189) % 20) == 19);
      end
      up = 1'b0;

      // request during INIT restarts INIT without counting
      run_to(1220);
      reset_pd_req = 1'b1;
      push(1222, v(1, 1, 0, 0, 2), "init_req_pend");
      push(1228, v(1, 1, 0, 0, 2), "init_extended");
      push(1238, v(1, 1, 0, 0, 2), "init_ext_last");
      push(1239, v(1, 0, 0, 0, 2), "init_ext_settle");
      push(1243, v(0, 0, 0, 0, 2), "init_ext_acq");
      run_to(1223);
      reset_pd_req = 1'b0;

      // request lands on the same edge as the 32nd quiet sample
      run_to(1272);
      reset_pd_req = 1'b1;
      push(1274, v(0, 0, 0, 0, 2), "race_pre");
      push(1275, v(1, 1, 0, 1, 3), "race_init_wins");
      push(1276, v(1, 1, 0, 0, 3), "race_after");
      run_to(1275);
      reset_pd_req = 1'b0;

      // two more recoveries (from SETTLE and ACQ) saturate the 2-bit count
      run_to(1290);
      reset_pd_req = 1'b1;
      push(1292, v(1, 0, 0, 0, 3), "sat_settle");
      push(1293, v(1, 1, 0, 1, 3), "sat_rec4");
      push(1294, v(1, 1, 0, 0, 3), "sat_rec4_end");
      run_to(1293);
      reset_pd_req = 1'b0;
      run_to(1317);
      reset_pd_req = 1'b1;
      push(1319, v(0, 0, 0, 0, 3), "sat_acq");
      push(1320, v(1, 1, 0, 1, 3), "sat_rec5");
      push(1321, v(1, 1, 0, 0, 3), "sat_rec5_end");
      run_to(1320);
      reset_pd_req = 1'b0;

      // asynchronous reset in the middle of ACQ
      push(1350, v(0, 0, 0, 0, 3), "pre_rst_acq");
      run_to(1351);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst", v(1, 1, 0, 0, 0));
      @(posedge clk_ext);
      #1;
      check("rst_held", v(1, 1, 0, 0, 0));
      rst = 1'b0;
      push(1,  v(1, 1, 0, 0, 0), "post_rst_init");
      push(15, v(1, 1, 0, 0, 0), "post_rst_init_last");
      push(16, v(1, 0, 0, 0, 0), "post_rst_settle");
      push(20, v(0, 0, 0, 0, 0), "post_rst_acq");
      run_to(25);

      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: observed %0d pending, expected 0", sb.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
